// File: rtl/stereo_pkg.sv
// Shared constants for the stereo filter pipeline: window height, default image geometry
// and the coordinate-width helper used by every stage.
package stereo_pkg;

    localparam int unsigned WIN        = 7;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IMG_W_DEF  = 640;
    localparam int unsigned IMG_H_DEF  = 480;

    // Bits needed to hold a coordinate in 0..n-1 (at least one bit)
    function automatic int unsigned coord_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/window_column_buffer_if.sv
// Pixel stream in, pixel column stream out, between the raster source and the window builder.
interface window_column_buffer_if #(
    parameter int unsigned DATA_W = stereo_pkg::DATA_W_DEF,
    parameter int unsigned WIN    = stereo_pkg::WIN,
    parameter int unsigned X_W    = stereo_pkg::coord_w(stereo_pkg::IMG_W_DEF),
    parameter int unsigned Y_W    = stereo_pkg::coord_w(stereo_pkg::IMG_H_DEF)
);

    logic [DATA_W-1:0]     pix_in;
    logic                  pix_valid;
    logic                  sof;
    logic [WIN*DATA_W-1:0] col_out;
    logic                  col_valid;
    logic [X_W-1:0]        col_x;
    logic [Y_W-1:0]        col_y;
    logic                  eof;

    modport master (
        output pix_in, pix_valid, sof,
        input  col_out, col_valid, col_x, col_y, eof
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output col_out, col_valid, col_x, col_y, eof
    );

endinterface

// File: rtl/line_ram.sv
// Single-port synchronous line memory with per-lane write enables; the read returns the
// contents from before a same-address write.
module line_ram #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned AW     = 10,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned LANES  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANES-1:0]        lane_we,
    input  logic [AW-1:0]           addr,
    input  logic [LANE_W-1:0]       wdata,
    output logic [LANES*LANE_W-1:0] q
);

    logic [LANES*LANE_W-1:0] mem [DEPTH];

    // Array write: no reset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/window_column_buffer.sv
// Raster line buffer: for each accepted pixel emits the WIN-tall column ending at it.
// Each RAM lane holds one line; lanes rotate per line so the write never depends on the read.
module window_column_buffer #(
    parameter int unsigned DATA_W = stereo_pkg::DATA_W_DEF,
    parameter int unsigned IMG_W  = stereo_pkg::IMG_W_DEF,
    parameter int unsigned IMG_H  = stereo_pkg::IMG_H_DEF,
    parameter int unsigned WIN    = stereo_pkg::WIN
) (
    input  logic                  clk,
    input  logic                  rst,
    window_column_buffer_if.slave bus
);

    localparam int unsigned ROWS  = WIN - 1;
    localparam int unsigned MEM_W = ROWS * DATA_W;
    localparam int unsigned X_W   = stereo_pkg::coord_w(IMG_W);
    localparam int unsigned Y_W   = stereo_pkg::coord_w(IMG_H);
    localparam int unsigned F_W   = stereo_pkg::coord_w(WIN);
    localparam int unsigned P_W   = stereo_pkg::coord_w(ROWS);

    logic [X_W-1:0]    x_q, x_cur, x_nxt;
    logic [Y_W-1:0]    y_q, y_cur, y_nxt;
    logic [F_W-1:0]    fill_q, fill_cur, fill_nxt;
    logic [P_W-1:0]    ptr_q, ptr_cur, ptr_nxt, ptr_d;
    logic              line_end, frame_end;
    logic [ROWS-1:0]   lane_we;
    logic [MEM_W-1:0]  ram_q, rows;
    logic [2*MEM_W-1:0] ram_dbl;
    logic [DATA_W-1:0] pix_q;
    logic              col_valid_q, eof_q;
    logic [X_W-1:0]    col_x_q;
    logic [Y_W-1:0]    col_y_q;

    // sof puts the accepted pixel at the frame origin with an empty fill history
    always_comb begin
        x_cur    = bus.sof ? '0 : x_q;
        y_cur    = bus.sof ? '0 : y_q;
        fill_cur = bus.sof ? '0 : fill_q;
        ptr_cur  = bus.sof ? '0 : ptr_q;

        line_end  = (x_cur == X_W'(IMG_W - 1));
        frame_end = line_end && (y_cur == Y_W'(IMG_H - 1));

        x_nxt    = line_end ? '0 : x_cur + X_W'(1);
        y_nxt    = y_cur;
        fill_nxt = fill_cur;
        ptr_nxt  = ptr_cur;

        if (frame_end) begin
            y_nxt    = '0;
            fill_nxt = '0;
            ptr_nxt  = '0;
        end else if (line_end) begin
            y_nxt = y_cur + Y_W'(1);
            if (fill_cur != F_W'(ROWS)) begin
                fill_nxt = fill_cur + F_W'(1);
            end
            ptr_nxt = (ptr_cur == P_W'(ROWS - 1)) ? '0 : ptr_cur + P_W'(1);
        end

        lane_we = ROWS'(1) << ptr_cur;
    end

    line_ram #(
        .DEPTH  (IMG_W),
        .AW     (X_W),
        .LANE_W (DATA_W),
        .LANES  (ROWS)
    ) u_line_ram (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.pix_valid),
        .lane_we (lane_we),
        .addr    (x_cur),
        .wdata   (bus.pix_in),
        .q       (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            fill_q <= '0;
            ptr_q  <= '0;
        end else if (bus.pix_valid) begin
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            fill_q <= fill_nxt;
            ptr_q  <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            pix_q       <= '0;
            ptr_d       <= '0;
            col_x_q     <= '0;
            col_y_q     <= '0;
        end else begin
            col_valid_q <= bus.pix_valid && (fill_cur >= F_W'(ROWS));
            eof_q       <= bus.pix_valid && frame_end;
            if (bus.pix_valid) begin
                pix_q   <= bus.pix_in;
                ptr_d   <= ptr_cur;
                col_x_q <= x_cur;
                col_y_q <= y_cur;
            end
        end
    end

    // Lane ptr_d holds the oldest line; rotate so it lands in row 0
    always_comb begin
        ram_dbl = {ram_q, ram_q};
        rows    = MEM_W'(ram_dbl >> (32'(ptr_d) * DATA_W));
    end

    assign bus.col_out   = {pix_q, rows};
    assign bus.col_valid = col_valid_q;
    assign bus.col_x     = col_x_q;
    assign bus.col_y     = col_y_q;
    assign bus.eof       = eof_q;

endmodule

// File: tb/tb_window_column_buffer.sv
// Directed bench for window_column_buffer on an 8x10 image with pixel value 16*y + x (+ offset).
module tb_window_column_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 8;
    localparam int unsigned IH = 10;
    localparam int unsigned WN = 7;
    localparam int unsigned XW = 3;
    localparam int unsigned YW = 4;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;
    int n_valid;
    int n_eof;
    int last_x;
    int last_y;
    bit last_ok;
    logic [55:0] last_col;

    window_column_buffer_if #(.DATA_W(DW), .WIN(WN), .X_W(XW), .Y_W(YW)) bus ();

    window_column_buffer #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .IMG_H  (IH),
        .WIN    (WN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Column of pixel (x,y): row k holds pixel (x, y-6+k)
    function automatic logic [55:0] col_of(input int x, input int y, input int off);
        logic [55:0] c;
        for (int k = 0; k < 7; k++) begin
            c[k*8 +: 8] = 8'(16 * (y - 6 + k) + x + off);
        end
        return c;
    endfunction

    task automatic send_px(input int x, input int y, input int off, input bit s);
        bit ev;
        logic [55:0] expc;
        @(negedge clk);
        bus.pix_in    = 8'(16 * y + x + off);
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        @(posedge clk);
        #1;
        ev   = (y >= 6);
        expc = col_of(x, y, off);
        check("col_valid", 64'(bus.col_valid), 64'(ev));
        check("eof", 64'(bus.eof), 64'(x == 7 && y == 9));
        check("col_x", 64'(bus.col_x), 64'(x));
        check("col_y", 64'(bus.col_y), 64'(y));
        if (ev) check("col_out", 64'(bus.col_out), 64'(expc));
        n_valid += int'(bus.col_valid);
        n_eof   += int'(bus.eof);
        last_x   = x;
        last_y   = y;
        last_ok  = ev;
        last_col = expc;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic gap(input bit s);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = s;
        bus.pix_in    = 8'($urandom);
        @(posedge clk);
        #1;
        check("gap_valid", 64'(bus.col_valid), 64'd0);
        check("gap_eof", 64'(bus.eof), 64'd0);
        check("gap_x", 64'(bus.col_x), 64'(last_x));
        check("gap_y", 64'(bus.col_y), 64'(last_y));
        if (last_ok) check("gap_col", 64'(bus.col_out), 64'(last_col));
        bus.sof = 1'b0;
    endtask

    // n pixels in raster order from (x0,y0); optional sof on the first, optional random gaps
    task automatic run_px(input int x0, input int y0, input int n, input int off,
                          input bit sof_first, input bit gaps);
        int x = x0;
        int y = y0;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) gap(1'($urandom_range(0, 1)));
            end
            send_px(x, y, off, sof_first && (i == 0));
            x++;
            if (x == int'(IW)) begin
                x = 0;
                y++;
                if (y == int'(IH)) y = 0;
            end
        end
    endtask

    initial begin
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        last_x = 0; last_y = 0; last_ok = 1'b0; last_col = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_col_out", 64'(bus.col_out), 64'd0);
        check("rst_valid", 64'(bus.col_valid), 64'd0);
        check("rst_x", 64'(bus.col_x), 64'd0);
        check("rst_y", 64'(bus.col_y), 64'd0);
        check("rst_eof", 64'(bus.eof), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Continuous frame with sof on the first pixel
        n_valid = 0; n_eof = 0;
        run_px(0, 0, 49, 0, 1'b1, 1'b0);
        check("first_col", 64'(bus.col_out), 64'h0060_5040_3020_1000);
        check("first_xy", 64'({bus.col_x, bus.col_y}), 64'({3'd0, 4'd6}));
        run_px(1, 6, 31, 0, 1'b0, 1'b0);
        check("a_nvalid", 64'(n_valid), 64'd32);
        check("a_neof", 64'(n_eof), 64'd1);

        // Same frame with random idle gaps, some carrying a stray sof
        n_valid = 0; n_eof = 0;
        run_px(0, 0, 80, 0, 1'b1, 1'b1);
        check("b_nvalid", 64'(n_valid), 64'd32);
        check("b_neof", 64'(n_eof), 64'd1);

        // sof with pix_valid low must not disturb the running coordinates
        run_px(0, 0, 20, 0, 1'b1, 1'b0);
        gap(1'b1);
        gap(1'b1);
        run_px(4, 2, 60, 0, 1'b0, 1'b0);

        // Restart mid-frame at pixel 3 of line 7
        run_px(0, 0, 7 * 8 + 3, 0, 1'b1, 1'b0);
        n_valid = 0;
        run_px(0, 0, 80, 0, 1'b1, 1'b0);
        check("c_nvalid", 64'(n_valid), 64'd32);

        // Two frames back-to-back, second without sof and with distinct data
        run_px(0, 0, 80, 0, 1'b1, 1'b0);
        n_valid = 0;
        run_px(0, 0, 80, 8, 1'b0, 1'b0);
        check("d_nvalid", 64'(n_valid), 64'd32);

        // Asynchronous reset in the middle of line 8
        run_px(0, 0, 8 * 8 + 4, 0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_col", 64'(bus.col_out), 64'd0);
        check("mid_rst_valid", 64'(bus.col_valid), 64'd0);
        check("mid_rst_x", 64'(bus.col_x), 64'd0);
        check("mid_rst_y", 64'(bus.col_y), 64'd0);
        check("mid_rst_eof", 64'(bus.eof), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_x = 0; last_y = 0; last_ok = 1'b0;
        run_px(0, 0, 8, 0, 1'b0, 1'b0);
        n_valid = 0; n_eof = 0;
        run_px(0, 0, 80, 0, 1'b1, 1'b0);
        check("e_nvalid", 64'(n_valid), 64'd32);
        check("e_neof", 64'(n_eof), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
